// File: rtl/fifo_pkg.sv
// Shared FIFO package.
// Holds the read-mode encodings and the pointer-width helper used by the
// single-clock FIFO (and by the dual-clock FIFO that shares this package).
package fifo_pkg;

    // Read-mode encodings for the FWFT parameter.
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM for the FIFO datapath.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - async active-low reset (read register only, array is not reset)
//   we     - write enable; mem[waddr] <= wdata
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata <= mem[raddr], otherwise rdata holds
//   raddr  - read address
//   rdata  - registered read data
// Read and write of the same address on the same edge returns the old
// contents; the FIFO top handles that case where it matters.
module fifo_mem_2p #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : fifo_mem_2p

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full / almost-empty
// thresholds, sticky overflow / underflow flags and selectable read mode.
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   wr_rq, wdata      - write request and data; accepted when !full
//   rd_rq             - read request (standard) / pop (FWFT); accepted when !empty
//   rdata, rvalid     - read data and its qualifier
//   full, empty       - count == DEPTH / count == 0
//   almost_full       - count >= AF_THRESH
//   almost_empty      - count <= AE_THRESH
//   count             - occupancy 0..DEPTH
//   overflow          - sticky: write attempted while full
//   underflow         - sticky: read attempted while empty
//   clr_err           - synchronous clear of both sticky flags (set wins)
//
// Handshake: a request is a level sampled at the rising edge; it takes
// effect only if accepted (write: !full, read: !empty). No ready signal is
// returned combinationally -- the producer/consumer look at full/empty,
// which reflect the state after the previous edge. In standard mode rvalid
// marks the single cycle after an accepted read; in FWFT mode rvalid means
// rdata currently holds the head entry and rd_rq pops it.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_rq,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_rq,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_LVL  = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL  = PTR_W'(AE_THRESH);
    localparam bit               IS_FWFT = (FWFT == MODE_FWFT);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             rvalid_q, rvalid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;

    logic             wr_accept;
    logic             rd_accept;
    logic             mem_re;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    // Status derived only from registered pointers.
    always_comb begin
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        empty = (wptr_q == rptr_q);
        count = wptr_q - rptr_q;
    end

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    always_comb begin
        wr_accept   = wr_rq && !full;
        rd_accept   = rd_rq && !empty;

        wptr_d      = wr_accept ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d      = rd_accept ? (rptr_q + PTR_ONE) : rptr_q;

        rvalid_d    = rd_accept;

        // Set has priority over clear on the same edge.
        overflow_d  = (wr_rq && full)  ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
        underflow_d = (rd_rq && empty) ? 1'b1 : (clr_err ? 1'b0 : underflow_q);

        // FWFT keeps the RAM output register loaded with the entry at the
        // next head pointer every cycle. Standard mode reads only on an
        // accepted read, so rdata holds between reads.
        if (IS_FWFT) begin
            mem_re    = 1'b1;
            mem_raddr = rptr_d[AW-1:0];
        end else begin
            mem_re    = rd_accept;
            mem_raddr = rptr_q[AW-1:0];
        end

        // When the next head slot is being written on this very edge the
        // RAM would return stale data, so the write data is forwarded.
        // This only happens in FWFT mode (write into empty, or pop+write
        // at count 1); in standard mode read and write never share a slot.
        byp_d      = IS_FWFT && wr_accept && (wptr_q[AW-1:0] == rptr_d[AW-1:0]);
        byp_data_d = wr_accept ? wdata : byp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            byp_q       <= byp_d;
            byp_data_q  <= byp_data_d;
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_accept),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign rdata     = byp_q ? byp_data_q : mem_rdata;
    assign rvalid    = IS_FWFT ? !empty : rvalid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : sync_fifo_flags

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int W = 4;
  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic         s_wr = 0, s_rd = 0, s_clr = 0;
  logic [W-1:0] s_wdata = '0;
  logic [W-1:0] s_rdata;
  logic         s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [3:0]   s_count;

  // FWFT instance
  logic         f_wr = 0, f_rd = 0, f_clr = 0;
  logic [W-1:0] f_wdata = '0;
  logic [W-1:0] f_rdata;
  logic         f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]   f_count;

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wr_rq(s_wr), .wdata(s_wdata), .rd_rq(s_rd),
    .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr)
  );

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_rq(f_wr), .wdata(f_wdata), .rd_rq(f_rd),
    .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr)
  );

  // ---------------- scoreboard / bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic std_idle();
    s_wr = 0; s_rd = 0; s_clr = 0;
  endtask

  task automatic fwft_idle();
    f_wr = 0; f_rd = 0; f_clr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [3:0] wd;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic       rv;
    logic       chk_rd;
    logic [3:0] rd_exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(input int wr, input int rd, input int clr, input int wd,
                              input int cnt, input int fl, input int em, input int af,
                              input int ae, input int ovf, input int unf, input int rv,
                              input int rde);
    vec_t v;
    v.wr     = 1'(wr);
    v.rd     = 1'(rd);
    v.clr    = 1'(clr);
    v.wd     = 4'(wd);
    v.cnt    = 4'(cnt);
    v.full   = 1'(fl);
    v.empty  = 1'(em);
    v.af     = 1'(af);
    v.ae     = 1'(ae);
    v.ovf    = 1'(ovf);
    v.unf    = 1'(unf);
    v.rv     = 1'(rv);
    v.chk_rd = (rde >= 0);
    v.rd_exp = 4'(rde);
    return v;
  endfunction

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // wr rd clr wd | cnt full empty af ae ovf unf rv rdata(-1 = skip)
    vecs[0]  = mk(1,0,0,1,  1,0,0,0,1,0,0,0, 0);
    vecs[1]  = mk(1,0,0,2,  2,0,0,0,1,0,0,0, 0);
    vecs[2]  = mk(1,0,0,3,  3,0,0,0,0,0,0,0, 0);
    vecs[3]  = mk(1,0,0,4,  4,0,0,0,0,0,0,0,-1);
    vecs[4]  = mk(1,0,0,5,  5,0,0,0,0,0,0,0,-1);
    vecs[5]  = mk(1,0,0,6,  6,0,0,1,0,0,0,0,-1);
    vecs[6]  = mk(1,0,0,7,  7,0,0,1,0,0,0,0,-1);
    vecs[7]  = mk(1,0,0,8,  8,1,0,1,0,0,0,0,-1);
    vecs[8]  = mk(1,0,0,9,  8,1,0,1,0,1,0,0,-1);   // rejected write -> overflow
    vecs[9]  = mk(0,0,1,0,  8,1,0,1,0,0,0,0,-1);   // clr_err
    vecs[10] = mk(0,1,0,0,  7,0,0,1,0,0,0,1, 1);
    vecs[11] = mk(0,1,0,0,  6,0,0,1,0,0,0,1, 2);
    vecs[12] = mk(0,1,0,0,  5,0,0,0,0,0,0,1, 3);
    vecs[13] = mk(0,1,0,0,  4,0,0,0,0,0,0,1, 4);
    vecs[14] = mk(0,1,0,0,  3,0,0,0,0,0,0,1, 5);
    vecs[15] = mk(0,1,0,0,  2,0,0,0,1,0,0,1, 6);
    vecs[16] = mk(0,1,0,0,  1,0,0,0,1,0,0,1, 7);
    vecs[17] = mk(0,1,0,0,  0,0,1,0,1,0,0,1, 8);
    vecs[18] = mk(0,1,0,0,  0,0,1,0,1,0,1,0, 8);   // rejected read -> underflow, rdata holds
    vecs[19] = mk(0,0,1,0,  0,0,1,0,1,0,0,0, 8);

    // ---------------- reset ----------------
    rst_n = 0;
    #22;
    rst_n = 1;
    tick();
    chk("rst_count",  32'(s_count), 32'd0);
    chk("rst_empty",  32'(s_empty), 32'd1);
    chk("rst_full",   32'(s_full),  32'd0);
    chk("rst_ae",     32'(s_ae),    32'd1);
    chk("rst_af",     32'(s_af),    32'd0);
    chk("rst_rvalid", 32'(s_rvalid),32'd0);
    chk("rst_rdata",  32'(s_rdata), 32'd0);
    chk("rst_ovf",    32'(s_ovf),   32'd0);
    chk("rst_unf",    32'(s_unf),   32'd0);
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);

    // ---------------- table: fill, overflow, drain, underflow ----------------
    for (int i = 0; i < NV; i++) begin
      s_wr = vecs[i].wr; s_rd = vecs[i].rd; s_clr = vecs[i].clr; s_wdata = vecs[i].wd;
      tick();
      chk($sformatf("v%0d_count", i),  32'(s_count),  32'(vecs[i].cnt));
      chk($sformatf("v%0d_full", i),   32'(s_full),   32'(vecs[i].full));
      chk($sformatf("v%0d_empty", i),  32'(s_empty),  32'(vecs[i].empty));
      chk($sformatf("v%0d_af", i),     32'(s_af),     32'(vecs[i].af));
      chk($sformatf("v%0d_ae", i),     32'(s_ae),     32'(vecs[i].ae));
      chk($sformatf("v%0d_ovf", i),    32'(s_ovf),    32'(vecs[i].ovf));
      chk($sformatf("v%0d_unf", i),    32'(s_unf),    32'(vecs[i].unf));
      chk($sformatf("v%0d_rvalid", i), 32'(s_rvalid), 32'(vecs[i].rv));
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), 32'(s_rdata), 32'(vecs[i].rd_exp));
    end
    std_idle();

    // ---------------- simultaneous read/write at count 3, wraps pointers ----------------
    for (int k = 0; k < 3; k++) begin
      s_wr = 1; s_wdata = 4'($urandom_range(0, 15));
      exp_q.push_back(s_wdata);
      tick();
    end
    s_wr = 0;
    chk("rw_pre_count", 32'(s_count), 32'd3);
    for (int k = 0; k < 20; k++) begin
      s_wr = 1; s_rd = 1; s_wdata = 4'($urandom_range(0, 15));
      exp_q.push_back(s_wdata);
      tick();
      exp_v = exp_q.pop_front();
      chk($sformatf("rw%0d_count", k),  32'(s_count),  32'd3);
      chk($sformatf("rw%0d_rvalid", k), 32'(s_rvalid), 32'd1);
      chk($sformatf("rw%0d_rdata", k),  32'(s_rdata),  32'(exp_v));
    end
    s_wr = 0;
    for (int k = 0; k < 3; k++) begin
      s_rd = 1;
      tick();
      exp_v = exp_q.pop_front();
      chk($sformatf("rwd%0d_rdata", k), 32'(s_rdata), 32'(exp_v));
    end
    s_rd = 0;
    tick();
    chk("rwd_empty",  32'(s_empty),  32'd1);
    chk("rwd_rvalid", 32'(s_rvalid), 32'd0);

    // ---------------- same-edge overflow set and clr_err ----------------
    for (int k = 0; k < D; k++) begin
      s_wr = 1; s_wdata = 4'(k + 3);
      tick();
    end
    chk("sc_full", 32'(s_full), 32'd1);
    s_wr = 1; s_clr = 1;
    tick();
    chk("sc_ovf_set_wins", 32'(s_ovf),   32'd1);
    chk("sc_count",        32'(s_count), 32'd8);
    s_wr = 0; s_clr = 1;
    tick();
    chk("sc_ovf_cleared", 32'(s_ovf), 32'd0);
    std_idle();

    // ---------------- reset mid-stream ----------------
    rst_n = 0;
    #2;
    rst_n = 1;
    tick();
    s_rd = 1;
    tick();
    s_rd = 0;
    chk("mr_unf_set", 32'(s_unf), 32'd1);
    for (int k = 0; k < 5; k++) begin
      s_wr = 1; s_wdata = 4'(k + 1);
      tick();
    end
    chk("mr_count5", 32'(s_count), 32'd5);
    s_rd = 1;               // requests still active when reset hits
    #3;
    rst_n = 0;
    #1;
    chk("mr_count",  32'(s_count),  32'd0);
    chk("mr_empty",  32'(s_empty),  32'd1);
    chk("mr_ae",     32'(s_ae),     32'd1);
    chk("mr_rvalid", 32'(s_rvalid), 32'd0);
    chk("mr_ovf",    32'(s_ovf),    32'd0);
    chk("mr_unf",    32'(s_unf),    32'd0);
    chk("mr_rdata",  32'(s_rdata),  32'd0);
    @(negedge clk);
    std_idle();
    rst_n = 1;
    tick();
    chk("mr_after_count", 32'(s_count), 32'd0);

    // ---------------- FWFT mode ----------------
    f_wr = 1; f_wdata = 4'hA;
    tick();
    f_wr = 0;
    chk("fw_a_rvalid", 32'(f_rvalid), 32'd1);
    chk("fw_a_rdata",  32'(f_rdata),  32'hA);
    f_wr = 1; f_wdata = 4'hB;
    tick();
    f_wr = 0;
    chk("fw_b_head",  32'(f_rdata), 32'hA);
    chk("fw_b_count", 32'(f_count), 32'd2);
    f_rd = 1;
    tick();
    chk("fw_pop1_rvalid", 32'(f_rvalid), 32'd1);
    chk("fw_pop1_rdata",  32'(f_rdata),  32'hB);
    tick();
    f_rd = 0;
    chk("fw_pop2_rvalid", 32'(f_rvalid), 32'd0);
    chk("fw_pop2_empty",  32'(f_empty),  32'd1);

    // write into empty, then pop and write on the same edge at count 1
    f_wr = 1; f_wdata = 4'hC;
    tick();
    chk("fw_c_rdata", 32'(f_rdata), 32'hC);
    f_wr = 1; f_rd = 1; f_wdata = 4'hD;
    tick();
    fwft_idle();
    chk("fw_d_rvalid", 32'(f_rvalid), 32'd1);
    chk("fw_d_rdata",  32'(f_rdata),  32'hD);
    chk("fw_d_count",  32'(f_count),  32'd1);
    f_rd = 1;
    tick();
    f_rd = 0;
    chk("fw_d_empty", 32'(f_empty), 32'd1);

    // burst then drain in order
    for (int k = 0; k < 5; k++) begin
      f_wr = 1; f_wdata = 4'($urandom_range(0, 15));
      exp_q.push_back(f_wdata);
      tick();
    end
    f_wr = 0;
    chk("fw_burst_count", 32'(f_count), 32'd5);
    for (int k = 0; k < 5; k++) begin
      exp_v = exp_q.pop_front();
      chk($sformatf("fw_drain%0d_rvalid", k), 32'(f_rvalid), 32'd1);
      chk($sformatf("fw_drain%0d_rdata", k),  32'(f_rdata),  32'(exp_v));
      f_rd = 1;
      tick();
      f_rd = 0;
    end
    chk("fw_drain_empty", 32'(f_empty), 32'd1);
    f_rd = 1;
    tick();
    f_rd = 0;
    chk("fw_unf", 32'(f_unf), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_flags

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO. It is the next generation of the team's dual-clock FIFO, for blocks that share one clock domain.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same domain. Keeps the wr_rq / rd_rq / full / empty semantics the team already uses.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 8, number of entries. Power of two, >=4.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH. Range 0..DEPTH-1.
- FWFT, 0, read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_rq  in  1  write request.
- wdata  in  WIDTH  write data, sampled on an accepted write.
- rd_rq  in  1  read request (standard mode) / pop (FWFT mode).
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata qualifier.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit, and pointers wrap modulo 2*DEPTH.
  - full = (addr bits equal) && (MSBs differ).
  - empty = (wptr == rptr).
  - count = wptr - rptr, modulo 2*DEPTH.
- Write is accepted iff wr_rq && !full. mem[wptr] <= wdata and wptr increments on that edge.
- Read is accepted iff rd_rq && !empty; rptr increments on that edge.
- Simultaneous accepted read and write: count is unchanged. When full, the write is rejected even if a read occurs in the same cycle. When empty, the read is rejected even if a write occurs in the same cycle.
- All flags and count are registered or derived from registered pointers. They reflect the state after the last edge, with no combinational path from wr_rq or rd_rq.
- FWFT=0 (standard mode):
  - On an accepted read, rdata <= mem[rptr] and rvalid <= 1 at the next edge, i.e. 1-cycle latency.
  - rvalid = 0 in any cycle following a non-accepted read.
  - rdata holds its last value when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - rvalid = !empty. rdata = head entry whenever rvalid = 1.
  - A write into an empty FIFO makes rvalid = 1 the cycle after the write edge.
  - rd_rq while rvalid = 1 pops the entry; the next entry, if any, is presented the following cycle.
  - rdata is don't-care while rvalid = 0.
- Error flags:
  - overflow <= 1 on any edge where wr_rq && full.
  - underflow <= 1 on any edge where rd_rq && empty.
  - Both flags hold until clr_err = 1 at an edge. If set and clear occur on the same edge, set wins.
  - A rejected request changes no pointer, count or data.
- Reset asserted mid-operation: all state returns to reset values immediately. Data in flight is discarded.

Decomposition:
- Shared package fifo_pkg:
  - function clog2-based pointer width: PTR_W = $clog2(DEPTH)+1.
  - localparams for read-mode encoding: MODE_STD = 0, MODE_FWFT = 1.
  - Shared with the async FIFO.
- One sub-module, fifo_mem_2p: simple dual-port RAM, synchronous write, registered read with read enable.
  - FWFT mode uses its registered read with a lookahead address (rptr + 1 on pop) to keep the datapath registered.

Test Plan:
- Reset: drive rst_n=0 mid-stream after 5 writes -> count=0, empty=1, almost_empty=1, rvalid=0, overflow=0, underflow=0.
- Fill and overflow (DEPTH=8, AF=6, STD mode):
  - Write 0x1..0x8 -> almost_full rises when count=6, full=1 at count=8.
  - A 9th write is rejected: count stays 8 and overflow=1.
  - Pulse clr_err -> overflow=0.
- Drain and underflow: read 8 times -> rdata = 0x1..0x8 in order, each 1 cycle after its rd_rq. Then empty=1, almost_empty=1 at count<=2, and a 9th rd_rq sets underflow=1.
- Simultaneous read and write at count=3 for 20 cycles with random data -> count stays 3 and the data order matches a scoreboard. Covers pointer wrap-around (more than 2*DEPTH pointer advances).
- FWFT=1: write 0xA to an empty FIFO -> rvalid=1 and rdata=0xA the next cycle with no rd_rq. Write 0xB, pop -> rdata=0xB the next cycle. Pop again -> rvalid=0, empty=1.
- Same-edge clr_err and overflow: full FIFO, wr_rq=1 and clr_err=1 on the same edge -> overflow remains 1.
